// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode selectors and
// the used-word counter width calculation.
package fifo_pkg;

  localparam int SHOW_AHEAD_OFF = 0;
  localparam int SHOW_AHEAD_ON  = 1;

  // A counter that must hold 0..depth inclusive needs one more code than depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sc_fifo_ctrl_if.sv
// Write/read handshake, status and error flags of the single-clock FIFO.
// The producer/consumer side uses master; the FIFO uses slave.
interface sc_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);

  logic                  flush_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_i;
  logic                  rd_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic [CNT_WIDTH-1:0]  used_words_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i, wr_data_i, wr_i, rd_i,
    input  rd_data_o, rd_valid_o, used_words_o, full_o, empty_o,
           almost_full_o, almost_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_data_i, wr_i, rd_i,
    output rd_data_o, rd_valid_o, used_words_o, full_o, empty_o,
           almost_full_o, almost_empty_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, separate clocks.
// Contents and read register are not reset.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  wr_clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_clk_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge wr_clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge rd_clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sc_fifo_ctrl.sv
// Single-clock FIFO controller over dual_port_ram: arbitrary depth, show-ahead or
// normal read mode, threshold flags, synchronous flush and sticky error flags.
module sc_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int SHOW_AHEAD = SHOW_AHEAD_ON,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input logic           clk_i,
  input logic           rst_i,
  sc_fifo_ctrl_if.slave bus
);

  if ((DEPTH < 2) || (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) ||
      (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_params
    $fatal(1, "sc_fifo_ctrl: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full_s, empty_s;
  logic                  wr_acc_s, rd_acc_s;
  logic                  ram_avail_s, ram_rd_s;
  logic [DATA_WIDTH-1:0] ram_data_s;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
    logic [ADDR_WIDTH-1:0] nxt;
    if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
      nxt = {ADDR_WIDTH{1'b0}};
    end else begin
      nxt = ptr + ADDR_WIDTH'(1);
    end
    return nxt;
  endfunction

  // Status decode and request qualification; full/empty are taken before the edge.
  always_comb begin
    full_s = (cnt_q == CNT_WIDTH'(DEPTH));
    if (SHOW_AHEAD == SHOW_AHEAD_ON) begin
      empty_s = !valid_q;
    end else begin
      empty_s = (cnt_q == {CNT_WIDTH{1'b0}});
    end
    wr_acc_s = bus.wr_i && !full_s && !bus.flush_i;
    rd_acc_s = bus.rd_i && !empty_s && !bus.flush_i;
    // In show-ahead mode the count includes the word parked in the output register.
    ram_avail_s = (cnt_q != CNT_WIDTH'(valid_q));
    if (SHOW_AHEAD == SHOW_AHEAD_ON) begin
      ram_rd_s = ram_avail_s && (!valid_q || rd_acc_s) && !bus.flush_i;
    end else begin
      ram_rd_s = rd_acc_s;
    end
  end

  // Next-state for pointers, counter, data-valid bit and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush_i) begin
      wr_ptr_d = {ADDR_WIDTH{1'b0}};
      rd_ptr_d = {ADDR_WIDTH{1'b0}};
      cnt_d    = {CNT_WIDTH{1'b0}};
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (ram_rd_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
      if (SHOW_AHEAD == SHOW_AHEAD_ON) begin
        if (ram_rd_s) begin
          valid_d = 1'b1;
        end else if (rd_acc_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end else begin
        valid_d = rd_acc_s;
      end
      ovf_d = ovf_q || (bus.wr_i && full_s);
      udf_d = udf_q || (bus.rd_i && empty_s);
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q <= {ADDR_WIDTH{1'b0}};
      cnt_q    <= {CNT_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .wr_clk_i  (clk_i),
    .wr_en_i   (wr_acc_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.wr_data_i),
    .rd_clk_i  (clk_i),
    .rd_en_i   (ram_rd_s),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_data_s)
  );

  assign bus.rd_data_o      = ram_data_s;
  assign bus.rd_valid_o     = valid_q;
  assign bus.used_words_o   = cnt_q;
  assign bus.full_o         = full_s;
  assign bus.empty_o        = empty_s;
  assign bus.almost_full_o  = (cnt_q >= CNT_WIDTH'(AF_LEVEL));
  assign bus.almost_empty_o = (cnt_q <= CNT_WIDTH'(AE_LEVEL));
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = udf_q;

endmodule

// File: tb/tb_sc_fifo_ctrl.sv
// Directed bench for sc_fifo_ctrl: a show-ahead and a normal-mode instance, DEPTH=6,
// with a queue of expected read data filled on accepted writes.
module tb_sc_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int CW    = cnt_width(DEPTH);

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  sc_fifo_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) sa_if ();
  sc_fifo_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) nm_if ();

  sc_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(SHOW_AHEAD_ON)) u_sa (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (sa_if)
  );

  sc_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(SHOW_AHEAD_OFF)) u_nm (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (nm_if)
  );

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] sb_q[$];
  int         mcount = 0;
  logic       movf   = 1'b0;
  logic       mudf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sa_empty"},  sa_if.empty_o, 1);
    chk({tag, "_sa_full"},   sa_if.full_o, 0);
    chk({tag, "_sa_used"},   sa_if.used_words_o, 0);
    chk({tag, "_sa_af"},     sa_if.almost_full_o, 0);
    chk({tag, "_sa_ae"},     sa_if.almost_empty_o, 1);
    chk({tag, "_sa_ovf"},    sa_if.overflow_o, 0);
    chk({tag, "_sa_udf"},    sa_if.underflow_o, 0);
    chk({tag, "_sa_rvalid"}, sa_if.rd_valid_o, 0);
    chk({tag, "_nm_empty"},  nm_if.empty_o, 1);
    chk({tag, "_nm_used"},   nm_if.used_words_o, 0);
    chk({tag, "_nm_rvalid"}, nm_if.rd_valid_o, 0);
    chk({tag, "_nm_ae"},     nm_if.almost_empty_o, 1);
  endtask

  // One cycle on the show-ahead instance; r is only issued when data is expected.
  task automatic sa_op(input logic w, input logic [7:0] d, input logic r);
    logic       w_acc;
    logic [7:0] exp_d;
    if (r) begin
      exp_d = (sb_q.size() > 0) ? sb_q[0] : 8'hxx;
      chk("sa_pop_avail", sa_if.empty_o, 0);
      chk("sa_pop_data", sa_if.rd_data_o, exp_d);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    w_acc = w && (mcount < DEPTH);
    if (w_acc) sb_q.push_back(d);
    if (w && !w_acc) movf = 1'b1;
    mcount = mcount + (w_acc ? 1 : 0) - (r ? 1 : 0);
    sa_if.wr_i      = w;
    sa_if.wr_data_i = d;
    sa_if.rd_i      = r;
    tick();
    sa_if.wr_i = 1'b0;
    sa_if.rd_i = 1'b0;
    chk("sa_used",  sa_if.used_words_o, mcount);
    chk("sa_full",  sa_if.full_o, (mcount == DEPTH));
    chk("sa_af",    sa_if.almost_full_o, (mcount >= DEPTH - 1));
    chk("sa_ae",    sa_if.almost_empty_o, (mcount <= 1));
    chk("sa_ovf",   sa_if.overflow_o, movf);
    chk("sa_udf",   sa_if.underflow_o, mudf);
  endtask

  initial begin
    int written;
    logic w;
    logic r;

    rst_i = 1'b0;
    sa_if.flush_i = 1'b0; sa_if.wr_i = 1'b0; sa_if.rd_i = 1'b0; sa_if.wr_data_i = 8'h00;
    nm_if.flush_i = 1'b0; nm_if.wr_i = 1'b0; nm_if.rd_i = 1'b0; nm_if.wr_data_i = 8'h00;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_i = 1'b1;
    tick();

    // Fill to full, then drain in order.
    for (int i = 0; i < DEPTH; i++) sa_op(1'b1, 8'h11 + 8'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) sa_op(1'b0, 8'h00, 1'b1);
    chk("sa_drained_empty", sa_if.empty_o, 1);
    chk("sa_drained_rvalid", sa_if.rd_valid_o, 0);

    // Write+read while full: write dropped, read performed, overflow held.
    for (int i = 0; i < DEPTH; i++) sa_op(1'b1, 8'h11 + 8'(i), 1'b0);
    sa_op(1'b1, 8'h99, 1'b1);
    sa_op(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) sa_op(1'b0, 8'h00, 1'b1);
    chk("sa_ovf_drain_empty", sa_if.empty_o, 1);

    // Single write into empty FIFO; early read underflows, data appears two cycles on.
    sa_op(1'b1, 8'hA5, 1'b0);
    chk("sa_lat_c1_empty", sa_if.empty_o, 1);
    sa_if.rd_i = 1'b1;
    tick();
    sa_if.rd_i = 1'b0;
    mudf = 1'b1;
    chk("sa_lat_c2_empty", sa_if.empty_o, 0);
    chk("sa_lat_c2_data", sa_if.rd_data_o, 8'hA5);
    chk("sa_lat_c2_udf", sa_if.underflow_o, 1);
    chk("sa_lat_c2_used", sa_if.used_words_o, 1);
    sa_op(1'b0, 8'h00, 1'b1);

    // Interleaved traffic of 10 words across the pointer wrap.
    written = 0;
    for (int k = 0; k < 40; k++) begin
      w = (written < 10) && (mcount < DEPTH) && ((k % 4) != 3);
      r = (sb_q.size() >= 2) && ((k % 3) != 0);
      sa_op(w, 8'h30 + 8'(written), r);
      if (w) written++;
    end
    sa_op(1'b0, 8'h00, 1'b0);
    while (sb_q.size() > 0) sa_op(1'b0, 8'h00, 1'b1);
    chk("sa_wrap_written", written, 10);

    // Flush with a concurrent write, while holding 4 words and a set overflow flag.
    for (int i = 0; i < DEPTH; i++) sa_op(1'b1, 8'h41 + 8'(i), 1'b0);
    sa_op(1'b1, 8'hEE, 1'b0);
    sa_op(1'b0, 8'h00, 1'b1);
    sa_op(1'b0, 8'h00, 1'b1);
    chk("sa_pre_flush_used", sa_if.used_words_o, 4);
    chk("sa_pre_flush_ovf", sa_if.overflow_o, 1);
    sa_if.flush_i = 1'b1; sa_if.wr_i = 1'b1; sa_if.wr_data_i = 8'h77;
    tick();
    sa_if.flush_i = 1'b0; sa_if.wr_i = 1'b0;
    sb_q.delete(); mcount = 0; movf = 1'b0; mudf = 1'b0;
    chk("sa_flush_used", sa_if.used_words_o, 0);
    chk("sa_flush_empty", sa_if.empty_o, 1);
    chk("sa_flush_ovf", sa_if.overflow_o, 0);
    chk("sa_flush_udf", sa_if.underflow_o, 0);
    sa_op(1'b0, 8'h00, 1'b0);
    chk("sa_flush_wr_ignored", sa_if.empty_o, 1);
    sa_op(1'b1, 8'h5A, 1'b0);
    sa_op(1'b0, 8'h00, 1'b0);
    sa_op(1'b0, 8'h00, 1'b1);

    // Normal mode: data and rd_valid one cycle after an accepted read, for one cycle only.
    nm_if.wr_i = 1'b1; nm_if.wr_data_i = 8'h01;
    tick();
    chk("nm_wr_lat_empty", nm_if.empty_o, 0);
    chk("nm_wr_lat_used", nm_if.used_words_o, 1);
    nm_if.wr_data_i = 8'h02;
    tick();
    nm_if.wr_i = 1'b0;
    chk("nm_idle_rvalid", nm_if.rd_valid_o, 0);
    nm_if.rd_i = 1'b1;
    tick();
    nm_if.rd_i = 1'b0;
    chk("nm_rd1_rvalid", nm_if.rd_valid_o, 1);
    chk("nm_rd1_data", nm_if.rd_data_o, 8'h01);
    chk("nm_rd1_used", nm_if.used_words_o, 1);
    tick();
    chk("nm_rd1_rvalid_drop", nm_if.rd_valid_o, 0);
    nm_if.rd_i = 1'b1;
    tick();
    nm_if.rd_i = 1'b0;
    chk("nm_rd2_rvalid", nm_if.rd_valid_o, 1);
    chk("nm_rd2_data", nm_if.rd_data_o, 8'h02);
    chk("nm_rd2_empty", nm_if.empty_o, 1);
    nm_if.rd_i = 1'b1;
    tick();
    nm_if.rd_i = 1'b0;
    chk("nm_udf", nm_if.underflow_o, 1);
    chk("nm_udf_rvalid", nm_if.rd_valid_o, 0);
    chk("nm_udf_used", nm_if.used_words_o, 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) sa_op(1'b1, 8'h61 + 8'(i), 1'b0);
    nm_if.wr_i = 1'b1; nm_if.wr_data_i = 8'h0F;
    tick();
    nm_if.wr_i = 1'b0;
    chk("pre_rst_sa_used", sa_if.used_words_o, 3);
    chk("pre_rst_nm_udf", nm_if.underflow_o, 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    sb_q.delete(); mcount = 0; movf = 1'b0; mudf = 1'b0;
    tick();
    rst_i = 1'b1;
    sa_op(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sc_fifo_ctrl.md
Name: sc_fifo_ctrl

Overview:
- Single-clock FIFO; next generation of the team's FIFO family, for same-domain buffering between pipeline stages.
- Generalised over the existing FIFOs:
  - arbitrary (non-power-of-two) depth
  - selectable show-ahead or normal read mode
  - programmable almost-full / almost-empty thresholds
  - synchronous flush
  - sticky overflow / underflow error flags
- Storage is the team's existing dual-port RAM, with both ports on one clock.

Parameters:
DATA_WIDTH, 8, word width in bits
DEPTH, 8, capacity in words; any value >= 2
SHOW_AHEAD, 1, 1 = first-word-fall-through, 0 = normal (data one cycle after rd_i)
AF_LEVEL, DEPTH-1, almost_full_o asserts when used words >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 1, almost_empty_o asserts when used words <= AE_LEVEL; legal range 0..DEPTH-1
ADDR_WIDTH, $clog2(DEPTH), RAM address width (derived)
CNT_WIDTH, $clog2(DEPTH+1), used-word counter width (derived)

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous clear of contents and flags
wr_data_i  in  DATA_WIDTH  write data
wr_i  in  1  write request
rd_i  in  1  read request (pop in show-ahead mode)
rd_data_o  out  DATA_WIDTH  read data
rd_valid_o  out  1  normal mode: rd_data_o valid this cycle; show-ahead mode: equals !empty_o
used_words_o  out  CNT_WIDTH  words accepted and not yet popped
full_o  out  1  used_words_o == DEPTH
empty_o  out  1  no word available to read
almost_full_o  out  1  threshold flag
almost_empty_o  out  1  threshold flag
overflow_o  out  1  sticky: write attempted while full
underflow_o  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_i low, asynchronous): pointers, counter, data-valid register and flags cleared.
  - Output values: empty_o=1, full_o=0, used_words_o=0, almost_full_o=0, almost_empty_o=1, overflow_o=0, underflow_o=0, rd_valid_o=0.
  - rd_data_o is don't-care whenever no valid data is indicated.
- Write accepted when wr_i && !full_o; writes RAM at wr_ptr.
  - wr_ptr increments; it wraps from DEPTH-1 to 0 (explicit compare, not power-of-two roll-over).
- Read accepted when rd_i && !empty_o; rd_ptr has the same wrap rule.
- used_words_o is a registered counter:
  - +1 on accepted write only; -1 on accepted read only; unchanged when both are accepted.
  - Never exceeds DEPTH; never underflows.
- full_o, almost_full_o and almost_empty_o are decoded combinationally from the registered counter, so they update the cycle after the causing edge.
- Flag evaluation order within a cycle: full_o/empty_o are evaluated before the edge.
  - Write while full with a simultaneous read: the write is dropped and the read is performed.
  - Read while empty with a simultaneous write: the read is dropped and the write is performed.
- Dropped write (wr_i && full_o) sets overflow_o from the next cycle. Dropped read (rd_i && empty_o) sets underflow_o likewise. Both stay set until flush_i or reset.
- Show-ahead mode:
  - The RAM read register acts as the output register, with an internal valid bit.
  - The RAM is read when unread RAM data exists and (the output register is empty, or a read is accepted).
  - empty_o = !valid bit.
  - Latency: a write accepted in cycle 0 into an empty FIFO gives empty_o=0 and valid rd_data_o in cycle 2.
  - Back-to-back pops stream one word per cycle.
- Normal mode:
  - empty_o = (used_words_o == 0).
  - Accepted read in cycle n gives rd_data_o valid and rd_valid_o=1 in cycle n+1 only.
  - Write-to-not-empty latency is 1 cycle.
- flush_i has priority over wr_i/rd_i in the same cycle; both are ignored.
  - Next cycle: state identical to post-reset.
  - RAM contents are not cleared.
- Parameter legality (DEPTH>=2 and the level ranges above) is checked at elaboration with a fatal error.

Decomposition:
- fifo_pkg: mode constants (SHOW_AHEAD_ON/OFF) and a function for the CNT_WIDTH calculation, shared with the rest of the FIFO family.
- Sub-module: existing dual_port_ram, with wr_clk_i and rd_clk_i both tied to clk_i.
- Pointer-wrap logic stays inline.

Test Plan:
- DEPTH=6, SHOW_AHEAD=1: write 0x11..0x16 in consecutive cycles -> full_o=1 after the 6th write; used_words_o=6; almost_full_o=1 from used=5; then pop 6 times -> data 0x11..0x16 in order, empty_o=1 after the last pop.
- DEPTH=6 full: wr_i=1 with data 0x99 and rd_i=1 in the same cycle -> 0x11 popped, used=5, 0x99 not stored, overflow_o=1 next cycle and held.
- Empty FIFO, SHOW_AHEAD=1: single write of 0xA5 in cycle 0 -> empty_o=0, rd_data_o=0xA5 in cycle 2; rd_i in cycle 1 -> underflow_o=1, no pointer change.
- SHOW_AHEAD=0: write 0x01, 0x02; rd_i in cycle n -> rd_valid_o=1, rd_data_o=0x01 in cycle n+1 only.
- Write 10 words / read 10 words interleaved across the DEPTH=6 wrap -> data order preserved; used_words_o tracks exactly, never > 6.
- Mid-operation: used=4 and overflow_o=1 when flush_i is asserted together with wr_i -> used=0, empty_o=1, overflow_o=0 next cycle. Separately, rst_i low mid-stream -> all outputs at reset values immediately, without a clock edge.
